// File: rtl/rot_shift_reg_seq_if.sv
// Command/data bundle for rot_shift_reg_seq.
// Handshake: the master pulses start (with dir/rot/fill/steps) while busy is low.
// The command is accepted on that edge. busy stays high while it executes.
// done pulses for one cycle when it completes. A parallel load aborts a
// running command without a done pulse.
// state_dbg mirrors the sequencer state (1 = RUN) for observation.
interface rot_shift_reg_seq_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              load;
    logic [WIDTH-1:0]  d;
    logic              start;
    logic              dir;
    logic              rot;
    logic              fill;
    logic [STEP_W-1:0] steps;
    logic [WIDTH-1:0]  q;
    logic              busy;
    logic              done;
    logic              state_dbg;

    modport master (
        output load, d, start, dir, rot, fill, steps,
        input  q, busy, done, state_dbg
    );

    modport slave (
        input  load, d, start, dir, rot, fill, steps,
        output q, busy, done, state_dbg
    );
endinterface

// File: rtl/rot_shift_reg_seq.sv
// Generic-width rotating/shifting register with parallel load and a
// multi-step command engine (start -> busy for the programmed steps -> done).
// Optional build macro ROTSHIFT_BARREL_EN: when defined, the whole move is
// applied in a single RUN cycle through a barrel rotator/shifter. The final q
// is the same in both builds; only the busy length differs.
module rot_shift_reg_seq #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic               clock,
    input  logic               resetn,
    rot_shift_reg_seq_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  q_q;
    logic [WIDTH-1:0]  move_d;
    logic              busy_q;
    logic              done_q;
    logic [STEP_W-1:0] cnt_q;
    logic              dir_q;
    logic              rot_q;
    logic              fill_q;

    // One-position move. dir=0 moves toward the MSB, dir=1 toward the LSB.
    // The vacated end takes the wrapped bit (rotate) or the fill bit (shift).
    function automatic logic [WIDTH-1:0] step_once(
        input logic [WIDTH-1:0] v,
        input logic             mv_dir,
        input logic             mv_rot,
        input logic             mv_fill
    );
        logic in_bit;
        if (!mv_dir) begin
            in_bit = mv_rot ? v[WIDTH-1] : mv_fill;
            return {v[WIDTH-2:0], in_bit};
        end else begin
            in_bit = mv_rot ? v[0] : mv_fill;
            return {in_bit, v[WIDTH-1:1]};
        end
    endfunction

    // Full multi-position move in one step. A rotate only needs n mod WIDTH
    // positions. A shift of WIDTH or more leaves nothing but fill.
    function automatic logic [WIDTH-1:0] barrel_move(
        input logic [WIDTH-1:0]  v,
        input logic              mv_dir,
        input logic              mv_rot,
        input logic              mv_fill,
        input logic [STEP_W-1:0] n
    );
        int               k;
        int               n_i;
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] res;
        ones = '1;
        mask = '0;
        n_i  = int'(n);
        k    = n_i % WIDTH;
        if (mv_rot) begin
            if (k == 0) begin
                res = v;
            end else if (!mv_dir) begin
                res = (v << k) | (v >> (WIDTH - k));
            end else begin
                res = (v >> k) | (v << (WIDTH - k));
            end
        end else begin
            if (n_i >= WIDTH) begin
                res = {WIDTH{mv_fill}};
            end else if (!mv_dir) begin
                mask = ~(ones << n_i);
                res  = (v << n_i) | (mv_fill ? mask : '0);
            end else begin
                mask = ~(ones >> n_i);
                res  = (v >> n_i) | (mv_fill ? mask : '0);
            end
        end
        return res;
    endfunction

    // Next register value for a RUN edge, driven only by the latched command.
`ifdef ROTSHIFT_BARREL_EN
    always_comb begin
        move_d = barrel_move(q_q, dir_q, rot_q, fill_q, cnt_q);
    end
`else
    always_comb begin
        move_d = step_once(q_q, dir_q, rot_q, fill_q);
    end
`endif

    // Sequencer and datapath. The priority on each edge is reset, then load, then start, then a run step.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        q_q <= bus.d;
                    end else if (bus.start) begin
                        if (bus.steps != '0) begin
                            // Capture the command so later input changes cannot disturb it.
                            dir_q   <= bus.dir;
                            rot_q   <= bus.rot;
                            fill_q  <= bus.fill;
                            cnt_q   <= bus.steps;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            // A zero-length command completes immediately without going busy.
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.load) begin
                        // Abort: the new data wins and no completion is signalled.
                        q_q     <= bus.d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        q_q <= move_d;
`ifdef ROTSHIFT_BARREL_EN
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
`else
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == STEP_W'(1)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q         = q_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = (state_q == RUN);

endmodule

// File: tb/tb_rot_shift_reg_seq.sv
// Directed bench for rot_shift_reg_seq (WIDTH=8, STEP_W=4), default or
// ROTSHIFT_BARREL_EN build.
module tb_rot_shift_reg_seq;

    logic clock;
    logic resetn;
    int   n_checks;
    int   n_errors;

    rot_shift_reg_seq_if #(.WIDTH(8), .STEP_W(4)) bus ();

    rot_shift_reg_seq #(.WIDTH(8), .STEP_W(4)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // Clock and reset.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks.
    task automatic do_load(input logic [7:0] val);
        bus.load = 1'b1;
        bus.d    = val;
        tick();
        bus.load = 1'b0;
    endtask

    // Issue a command, scramble the inputs afterwards, and wait (bounded) for completion.
    task automatic run_cmd(input logic c_dir, input logic c_rot, input logic c_fill,
                           input logic [3:0] n, output int busy_cycles);
        bus.dir   = c_dir;
        bus.rot   = c_rot;
        bus.fill  = c_fill;
        bus.steps = n;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.dir   = ~c_dir;
        bus.rot   = ~c_rot;
        bus.fill  = ~c_fill;
        bus.steps = 4'hF;
        busy_cycles = 0;
        for (int i = 0; i < 40 && bus.busy; i++) begin
            busy_cycles++;
            tick();
        end
        check("done_at_end", bus.done, 1);
        check("idle_at_end", bus.state_dbg, 0);
        tick();
        check("done_one_cycle", bus.done, 0);
    endtask

    int nb;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        resetn    = 1'b0;
        bus.load  = 1'b0;
        bus.d     = '0;
        bus.start = 1'b0;
        bus.dir   = 1'b0;
        bus.rot   = 1'b0;
        bus.fill  = 1'b0;
        bus.steps = '0;

        // Reset and load.
        tick();
        tick();
        check("rst_q", bus.q, 8'h00);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_state", bus.state_dbg, 0);
        resetn = 1'b1;
        do_load(8'hA5);
        check("load_q", bus.q, 8'hA5);

        // Rotate toward MSB by 3 from 0x81, inputs changed after acceptance.
        do_load(8'h81);
        bus.dir = 1'b0; bus.rot = 1'b1; bus.steps = 4'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.dir = 1'b1; bus.rot = 1'b0; bus.steps = 4'd0;
        check("rot3_accept_busy", bus.busy, 1);
        check("rot3_accept_q", bus.q, 8'h81);
`ifdef ROTSHIFT_BARREL_EN
        tick();
`else
        tick();
        check("rot3_q1", bus.q, 8'h03);
        check("rot3_busy1", bus.busy, 1);
        check("rot3_done1", bus.done, 0);
        tick();
        check("rot3_q2", bus.q, 8'h06);
        check("rot3_busy2", bus.busy, 1);
        tick();
`endif
        check("rot3_q_final", bus.q, 8'h0C);
        check("rot3_busy_final", bus.busy, 0);
        check("rot3_done", bus.done, 1);
        tick();
        check("rot3_done_clear", bus.done, 0);

        // Fill-shift toward LSB by 10 from 0xF0 with fill=1.
        do_load(8'hF0);
        run_cmd(1'b1, 1'b0, 1'b1, 4'd10, nb);
`ifdef ROTSHIFT_BARREL_EN
        check("shr10_busy_len", nb, 1);
`else
        check("shr10_busy_len", nb, 10);
`endif
        check("shr10_q", bus.q, 8'hFF);

        // Rotate toward LSB by 11 (same as 3) from 0x96.
        do_load(8'h96);
        run_cmd(1'b1, 1'b1, 1'b0, 4'd11, nb);
`ifdef ROTSHIFT_BARREL_EN
        check("ror11_busy_len", nb, 1);
`else
        check("ror11_busy_len", nb, 11);
`endif
        check("ror11_q", bus.q, 8'hD2);

        // Maximum count: shift toward MSB by 15 with fill=0 clears 0xFF.
        do_load(8'hFF);
        run_cmd(1'b0, 1'b0, 1'b0, 4'd15, nb);
`ifdef ROTSHIFT_BARREL_EN
        check("shl15_busy_len", nb, 1);
`else
        check("shl15_busy_len", nb, 15);
`endif
        check("shl15_q", bus.q, 8'h00);

        // Abort by load, with an ignored start while busy.
        do_load(8'h01);
        bus.dir = 1'b0; bus.rot = 1'b1; bus.steps = 4'd8; bus.start = 1'b1;
        tick();
        check("abort_busy", bus.busy, 1);
`ifndef ROTSHIFT_BARREL_EN
        bus.steps = 4'd1;
        tick();
        bus.start = 1'b0;
        check("abort_q1", bus.q, 8'h02);
        check("abort_still_busy", bus.busy, 1);
        tick();
        check("abort_q2", bus.q, 8'h04);
`else
        bus.start = 1'b0;
`endif
        bus.load = 1'b1;
        bus.d    = 8'h3C;
        tick();
        bus.load = 1'b0;
        check("abort_q", bus.q, 8'h3C);
        check("abort_busy_low", bus.busy, 0);
        check("abort_no_done", bus.done, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_quiet_done", bus.done, 0);
            check("abort_quiet_q", bus.q, 8'h3C);
        end

        // Zero steps, then back-to-back start in the done cycle.
        bus.steps = 4'd0; bus.start = 1'b1;
        tick();
        check("zero_done", bus.done, 1);
        check("zero_busy", bus.busy, 0);
        check("zero_q", bus.q, 8'h3C);
        bus.dir = 1'b0; bus.rot = 1'b1; bus.steps = 4'd2;
        tick();
        bus.start = 1'b0;
        check("b2b_busy", bus.busy, 1);
        check("b2b_done_clear", bus.done, 0);
        for (int i = 0; i < 40 && bus.busy; i++) tick();
        check("b2b_q", bus.q, 8'hF0);
        check("b2b_done", bus.done, 1);
        tick();

        // Reset during RUN, then a normal command.
        do_load(8'h55);
        bus.dir = 1'b0; bus.rot = 1'b1; bus.steps = 4'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("mid_busy", bus.busy, 1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("mid_rst_q", bus.q, 8'h00);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        tick();
        check("mid_rst_done_after", bus.done, 0);
        do_load(8'h0F);
        run_cmd(1'b0, 1'b1, 1'b0, 4'd4, nb);
`ifdef ROTSHIFT_BARREL_EN
        check("post_rst_busy_len", nb, 1);
`else
        check("post_rst_busy_len", nb, 4);
`endif
        check("post_rst_q", bus.q, 8'hF0);

        // Final report.
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
